j1_pad_arbiter: RTL and testbench
=================================

# j1_pad_arbiter

Shares the 8-bit pmodA pad bank between the J1 core and the Caravel management SoC. The block is a Wishbone slave in `user_project_wrapper`, sitting between the J1Asic pmodA ports and `io_in/io_out/io_oeb[37:30]`. Ownership is granted through a four-state FSM with tri-state guard intervals, and host ownership can be bounded by a lease timer. Lease expiry is reported on an interrupt line that is mapped to `user_irq[0]`.

## Interface
- `BASE_ADR`, default 32'h3000_0000, Wishbone base; decode is `wbs_adr_i[31:8] == BASE_ADR[31:8]`.
- `GUARD_CYCLES`, default 4, all-hi-z cycles on each ownership change; minimum 1.
- `wb_clk_i` in 1: sole clock.
- `wb_rst_i` in 1: reset; synchronous, active-high.
- `wbs_stb_i`, `wbs_cyc_i`, `wbs_we_i` in 1 each: Wishbone control.
- `wbs_sel_i` in 4: byte lanes.
- `wbs_adr_i`, `wbs_dat_i` in 32 each: address and write data.
- `wbs_ack_o` out 1: acknowledge.
- `wbs_dat_o` out 32: read data.
- `core_write`, `core_oeb` in 8 each: J1 pmodA output value and output-enable-bar.
- `core_hold` in 1: J1 lock; while high, the J1 keeps the pads.
- `core_read` out 8: pad value presented to J1.
- `pad_in` in 8: `io_in[37:30]`.
- `pad_out`, `pad_oeb` out 8 each: drive `io_out/io_oeb[37:30]`.
- `irq` out 1: lease-expired interrupt.

## Operation
- **Registers** (word offset `adr[4:2]`; byte lanes honoured per byte; unused bits read 0):
  - 0x00 CTRL: bit0 `req` (host wants pads), bit1 `ie`.
  - 0x04 STATUS (RO except bit2): bit0 `host_owns` (state==HOST), bit1 `pending` (`req` & state==CORE & `core_hold`), bit2 `expired` (sticky; W1C).
  - 0x08 HOUT[7:0]: host output value.
  - 0x0C HOEB[7:0]: host oeb.
  - 0x10 PIN[7:0]: `pad_in` (RO).
  - 0x14 LEASE[15:0]: host lease in cycles; 0 means unlimited.
  - 0x18 and 0x1C: read 0, writes ignored.
- **FSM states:** CORE, GUARD_IN, HOST, GUARD_OUT.
  - CORE → GUARD_IN when `req & !core_hold`.
  - GUARD_IN → HOST after GUARD_CYCLES cycles; the lease counter loads LEASE on this transition.
  - GUARD_IN → CORE immediately if `req` is 0. The pads are already hi-z, so there is no contention.
  - HOST → GUARD_OUT when `req` is 0, or when LEASE≠0 and the counter equals 1. On expiry, hardware clears `req` and sets `expired`.
  - GUARD_OUT → CORE after GUARD_CYCLES cycles. The guard is never aborted. From CORE the request is re-arbitrated, so CORE always lasts at least 1 cycle.
- **Pad mux** (combinational from the registered state):
  - CORE: `pad_out=core_write`, `pad_oeb=core_oeb`, `core_read=pad_in`.
  - GUARD_*: `pad_out=0`, `pad_oeb=8'hFF`, `core_read=0`.
  - HOST: `pad_out=HOUT`, `pad_oeb=HOEB`, `core_read=0`.
- The lease counter is 16 bits and decrements once per HOST cycle. HOST therefore lasts exactly LEASE cycles. The counter never wraps.
- `irq = expired & ie`, registered.
- A simultaneous hardware set and W1C of `expired` resolves to set. A hardware clear of `req` on expiry wins over a same-cycle host write of `req=1`.
- **Reset:**
  - State CORE; all registers 0; `ack`, `irq` and `dat_o` are 0.
  - Reset asserted mid-HOST or mid-guard returns the pads to the core at the first edge with reset high. No guard interval is inserted on reset.

## Timing
- Wishbone: `ack` is asserted 1 cycle after `stb&cyc` with a matched address, for exactly 1 cycle. `ack` is low the following cycle, so back-to-back accesses take 2 cycles each. An unmatched address gets no ack.
- Register writes take effect on the ack edge. Read data is registered alongside ack.
- Handover: a CTRL write of `req=1` acked at edge t puts the FSM in GUARD_IN from edge t+1. The first HOST cycle starts at edge t+1+GUARD_CYCLES.
- Release: `req=0` acked at edge t puts the FSM in GUARD_OUT at t+1, with the core regaining the pads at t+1+GUARD_CYCLES.
- Expiry: with LEASE=N, HOST occupies N cycles. `expired` is set, and `irq` rises 1 cycle later.

## Test plan
- Reset, then read all registers → all read 0; `pad_oeb==core_oeb`; `core_read==pad_in`.
- `core_oeb=8'h00`, `core_write=8'hA5`; write HOEB=0, HOUT=8'h3C, CTRL=1 → `pad_oeb=8'hFF` for exactly 4 cycles, then `pad_out=8'h3C` and STATUS=1. Write CTRL=0 → 4 guard cycles, then `pad_out=8'hA5`.
- `core_hold=1` and CTRL=1 → STATUS.pending=1 and state stays CORE. Drop `core_hold` → handover per timing.
- LEASE=10, `ie=1`, CTRL=1 → HOST for exactly 10 cycles, then GUARD_OUT; CTRL reads 0, `expired=1`, `irq=1`. W1C STATUS=4 → `irq=0`.
- Assert `wb_rst_i` for 1 cycle while in HOST → pads follow the core from the next cycle; all registers read 0.
- Write CTRL=1, then CTRL=0 two cycles later (during GUARD_IN) → FSM returns directly to CORE; HOST is never entered.

Source files
------------

// File: rtl/j1_pad_arbiter.sv
// Shares the pmodA pad bank between the J1 core and the management SoC.
// Wishbone register slave plus a four-state ownership FSM with hi-z guard intervals and a host lease timer.
module j1_pad_arbiter #(
  parameter logic [31:0] BASE_ADR     = 32'h3000_0000,
  parameter int          GUARD_CYCLES = 4
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  input  logic [7:0]  core_write,
  input  logic [7:0]  core_oeb,
  input  logic        core_hold,
  output logic [7:0]  core_read,
  input  logic [7:0]  pad_in,
  output logic [7:0]  pad_out,
  output logic [7:0]  pad_oeb,
  output logic        irq
);

  localparam int GW = (GUARD_CYCLES < 2) ? 1 : $clog2(GUARD_CYCLES);
  localparam logic [GW-1:0] GUARD_LAST = GW'(GUARD_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_CORE      = 2'd0,
    ST_GUARD_IN  = 2'd1,
    ST_HOST      = 2'd2,
    ST_GUARD_OUT = 2'd3
  } state_t;

  state_t state;
  state_t state_nxt;

  // Host-visible registers
  logic        req;
  logic        ie;
  logic        expired;
  logic [7:0]  hout;
  logic [7:0]  hoeb;
  logic [15:0] lease;

  logic [GW-1:0] guard_cnt;
  logic [15:0]   lease_cnt;

  logic          wb_hit;
  logic          wb_req;
  logic          wb_wr;
  logic          wb_rd;
  logic [2:0]    word;
  logic [31:0]   rdata;
  logic          guard_done;
  logic          lease_expire;
  logic          pending;
  logic          unused_inputs;

  // Valid/ready: a transfer is a matched stb&cyc cycle with ack low; ack answers
  // it one cycle later for one cycle, so the master must drop stb on ack.
  assign wb_hit = wbs_stb_i & wbs_cyc_i & (wbs_adr_i[31:8] == BASE_ADR[31:8]);
  assign wb_req = wb_hit & ~wbs_ack_o;
  assign wb_wr  = wb_req & wbs_we_i;
  assign wb_rd  = wb_req & ~wbs_we_i;
  assign word   = wbs_adr_i[4:2];

  assign unused_inputs = ^{wbs_adr_i[7:5], wbs_adr_i[1:0], wbs_sel_i[3:2], wbs_dat_i[31:16]};

  assign guard_done   = (guard_cnt == '0);
  assign lease_expire = (state == ST_HOST) && (lease != 16'd0) && (lease_cnt == 16'd1);
  assign pending      = req & (state == ST_CORE) & core_hold;

  // FSM state register
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state <= ST_CORE;
    else          state <= state_nxt;
  end

  // FSM next state
  always_comb begin
    state_nxt = state;
    case (state)
      ST_CORE:      if (req && !core_hold) state_nxt = ST_GUARD_IN;
      ST_GUARD_IN: begin
        // Pads are already hi-z here, so a withdrawn request can return at once.
        if (!req)            state_nxt = ST_CORE;
        else if (guard_done) state_nxt = ST_HOST;
      end
      ST_HOST:      if (!req || lease_expire) state_nxt = ST_GUARD_OUT;
      ST_GUARD_OUT: if (guard_done) state_nxt = ST_CORE;
      default:      state_nxt = ST_CORE;
    endcase
  end

  // Guard and lease counters
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      guard_cnt <= '0;
      lease_cnt <= 16'd0;
    end else begin
      if ((state_nxt == ST_GUARD_IN  && state != ST_GUARD_IN) ||
          (state_nxt == ST_GUARD_OUT && state != ST_GUARD_OUT))
        guard_cnt <= GUARD_LAST;
      else if (!guard_done)
        guard_cnt <= guard_cnt - 1'b1;

      if (state == ST_GUARD_IN && state_nxt == ST_HOST)
        lease_cnt <= lease;
      else if (state == ST_HOST && lease_cnt != 16'd0)
        lease_cnt <= lease_cnt - 16'd1;
    end
  end

  // Register file, bus response and interrupt
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      req       <= 1'b0;
      ie        <= 1'b0;
      expired   <= 1'b0;
      hout      <= 8'h00;
      hoeb      <= 8'h00;
      lease     <= 16'd0;
      irq       <= 1'b0;
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= 32'd0;
    end else begin
      if (wb_wr) begin
        case (word)
          3'd0: if (wbs_sel_i[0]) begin
            req <= wbs_dat_i[0];
            ie  <= wbs_dat_i[1];
          end
          3'd1: if (wbs_sel_i[0] && wbs_dat_i[2]) expired <= 1'b0;
          3'd2: if (wbs_sel_i[0]) hout <= wbs_dat_i[7:0];
          3'd3: if (wbs_sel_i[0]) hoeb <= wbs_dat_i[7:0];
          3'd5: begin
            if (wbs_sel_i[0]) lease[7:0]  <= wbs_dat_i[7:0];
            if (wbs_sel_i[1]) lease[15:8] <= wbs_dat_i[15:8];
          end
          default: ;
        endcase
      end
      // Expiry overrides any same-cycle host write of req or W1C of expired.
      if (lease_expire) begin
        req     <= 1'b0;
        expired <= 1'b1;
      end
      irq       <= expired & ie;
      wbs_ack_o <= wb_req;
      wbs_dat_o <= wb_rd ? rdata : 32'd0;
    end
  end

  // Read mux
  always_comb begin
    rdata = 32'd0;
    case (word)
      3'd0: rdata = {30'd0, ie, req};
      3'd1: rdata = {29'd0, expired, pending, (state == ST_HOST)};
      3'd2: rdata = {24'd0, hout};
      3'd3: rdata = {24'd0, hoeb};
      3'd4: rdata = {24'd0, pad_in};
      3'd5: rdata = {16'd0, lease};
      default: rdata = 32'd0;
    endcase
  end

  // Pad mux
  always_comb begin
    pad_out   = 8'h00;
    pad_oeb   = 8'hFF;
    core_read = 8'h00;
    case (state)
      ST_CORE: begin
        pad_out   = core_write;
        pad_oeb   = core_oeb;
        core_read = pad_in;
      end
      ST_HOST: begin
        pad_out = hout;
        pad_oeb = hoeb;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_j1_pad_arbiter.sv
// Directed bench for j1_pad_arbiter: register access, handover/release timing,
// hold, lease expiry with interrupt, reset mid-host and guard abort.
module tb_j1_pad_arbiter;

  localparam logic [31:0] BASE = 32'h3000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        stb, cyc, we;
  logic [3:0]  sel;
  logic [31:0] adr, dat;
  logic        ack;
  logic [31:0] dat_o;
  logic [7:0]  core_write, core_oeb;
  logic        core_hold;
  logic [7:0]  core_read;
  logic [7:0]  pad_in;
  logic [7:0]  pad_out, pad_oeb;
  logic        irq;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  j1_pad_arbiter #(.BASE_ADR(BASE), .GUARD_CYCLES(4)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_adr_i(adr), .wbs_dat_i(dat), .wbs_ack_o(ack), .wbs_dat_o(dat_o),
    .core_write(core_write), .core_oeb(core_oeb), .core_hold(core_hold),
    .core_read(core_read), .pad_in(pad_in),
    .pad_out(pad_out), .pad_oeb(pad_oeb), .irq(irq)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic wb_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s = 4'hF);
    bit got_ack = 1'b0;
    @(negedge clk);
    stb = 1'b1; cyc = 1'b1; we = 1'b1; adr = a; dat = d; sel = s;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ack) begin got_ack = 1'b1; break; end
    end
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
    if (!got_ack) check("wr_ack_timeout", 32'd0, 32'd1);
  endtask

  task automatic wb_read(input logic [31:0] a, output logic [31:0] d);
    bit got_ack = 1'b0;
    @(negedge clk);
    stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = a; sel = 4'hF;
    d = 32'hDEAD_BEEF;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ack) begin got_ack = 1'b1; d = dat_o; break; end
    end
    stb = 1'b0; cyc = 1'b0;
    if (!got_ack) check("rd_ack_timeout", 32'd0, 32'd1);
  endtask

  task automatic rd_check(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] d;
    wb_read(a, d);
    check(tag, d, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; stb = 1'b0; cyc = 1'b0; we = 1'b0; sel = 4'h0; adr = 32'd0; dat = 32'd0;
    core_write = 8'hA5; core_oeb = 8'h00; core_hold = 1'b0; pad_in = 8'h00;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_ack", ack, 0);
    check("rst_irq", irq, 0);
    check("rst_dat", dat_o, 0);
    check("rst_pad_out", pad_out, 8'hA5);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) rd_check("reset_reg", BASE + 32'(i * 4), 32'd0);

    pad_in = 8'h5A; core_oeb = 8'h0F;
    @(negedge clk);
    check("core_read", core_read, 8'h5A);
    check("core_oeb", pad_oeb, 8'h0F);
    rd_check("pin", BASE + 32'h10, 32'h5A);
    core_oeb = 8'h00;

    // Unmatched address gets no ack
    @(negedge clk);
    stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = BASE + 32'h100;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("nomatch_ack", ack, 0);
    end
    stb = 1'b0; cyc = 1'b0;

    // Byte lanes on LEASE
    wb_write(BASE + 32'h14, 32'h0000_FFFF, 4'b0001);
    rd_check("lease_lane0", BASE + 32'h14, 32'h0000_00FF);
    wb_write(BASE + 32'h14, 32'h0000_1234, 4'b0010);
    rd_check("lease_lane1", BASE + 32'h14, 32'h0000_12FF);
    wb_write(BASE + 32'h14, 32'h0);

    // Handover and release
    wb_write(BASE + 32'h0C, 32'h00);
    wb_write(BASE + 32'h08, 32'h3C);
    wb_write(BASE + 32'h00, 32'h1);
    check("pre_guard_out", pad_out, 8'hA5);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("guard_in_oeb", pad_oeb, 8'hFF);
      check("guard_in_out", pad_out, 8'h00);
    end
    @(negedge clk);
    check("host_out", pad_out, 8'h3C);
    check("host_oeb", pad_oeb, 8'h00);
    check("host_core_read", core_read, 8'h00);
    rd_check("status_host", BASE + 32'h04, 32'h1);
    wb_write(BASE + 32'h00, 32'h0);
    check("still_host", pad_out, 8'h3C);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("guard_out_oeb", pad_oeb, 8'hFF);
    end
    @(negedge clk);
    check("release_out", pad_out, 8'hA5);
    check("release_oeb", pad_oeb, 8'h00);

    // Core hold blocks the request
    core_hold = 1'b1;
    wb_write(BASE + 32'h00, 32'h1);
    repeat (3) @(negedge clk);
    rd_check("status_pending", BASE + 32'h04, 32'h2);
    check("hold_out", pad_out, 8'hA5);
    core_hold = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("hold_guard_oeb", pad_oeb, 8'hFF);
    end
    @(negedge clk);
    check("hold_host_out", pad_out, 8'h3C);
    wb_write(BASE + 32'h00, 32'h0);
    repeat (6) @(negedge clk);
    check("hold_release", pad_out, 8'hA5);

    // Lease expiry and interrupt
    wb_write(BASE + 32'h14, 32'd10);
    wb_write(BASE + 32'h00, 32'h3);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("lease_guard_in", pad_oeb, 8'hFF);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("lease_host", pad_out, 8'h3C);
    end
    @(negedge clk);
    check("lease_guard_out", pad_oeb, 8'hFF);
    check("irq_not_yet", irq, 0);
    @(negedge clk);
    check("irq_set", irq, 1);
    rd_check("ctrl_req_cleared", BASE + 32'h00, 32'h2);
    rd_check("status_expired", BASE + 32'h04, 32'h4);
    wb_write(BASE + 32'h04, 32'h4);
    check("irq_w1c_lag", irq, 1);
    @(negedge clk);
    check("irq_cleared", irq, 0);
    rd_check("status_w1c", BASE + 32'h04, 32'h0);
    check("lease_back_core", pad_out, 8'hA5);
    wb_write(BASE + 32'h14, 32'd0);

    // Reset in the middle of HOST
    wb_write(BASE + 32'h00, 32'h1);
    repeat (6) @(negedge clk);
    check("pre_rst_host", pad_out, 8'h3C);
    rst = 1'b1;
    @(negedge clk);
    check("rst_pad_core", pad_out, 8'hA5);
    check("rst_oeb_core", pad_oeb, 8'h00);
    check("rst_core_read", core_read, 8'h5A);
    rst = 1'b0;
    for (int i = 0; i < 8; i++)
      rd_check("post_rst_reg", BASE + 32'(i * 4), (i == 4) ? 32'h5A : 32'h0);

    // Request withdrawn during GUARD_IN
    wb_write(BASE + 32'h00, 32'h1);
    wb_write(BASE + 32'h00, 32'h0);
    check("abort_guard", pad_oeb, 8'hFF);
    @(negedge clk);
    check("abort_core_out", pad_out, 8'hA5);
    check("abort_core_oeb", pad_oeb, 8'h00);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("abort_stay_core", pad_out, 8'hA5);
    end
    rd_check("abort_status", BASE + 32'h04, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
